// File: rtl/mult_div_unit_if.sv
// EX-stage <-> multiply/divide unit bundle: issue (start/op/operands) in,
// busy/md_stall status and the HI/LO registers out.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning HI/LO: MULT/MULTU/DIV/DIVU with fixed latency,
// MTHI/MTLO in one cycle. Ports: clk, reset (sync, active-high), md (slave).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            busy_q, busy_d;

  logic            is_div;
  logic            is_uns;
  logic [63:0]     a64, b64, prod;
  logic            neg_a, neg_b;
  logic [31:0]     ua, ub, ub_safe;
  logic [31:0]     uq, ur, quo, rem;
  logic [31:0]     res_hi, res_lo;

  assign is_div = md.op[1];
  assign is_uns = md.op[0];

  // Low 64 bits of the product of the extended operands equal the
  // signed or unsigned 32x32 product, so one multiplier serves both.
  always_comb begin
    a64  = is_uns ? {32'b0, md.rs_val}
                  : {{32{md.rs_val[31]}}, md.rs_val};
    b64  = is_uns ? {32'b0, md.rt_val}
                  : {{32{md.rt_val[31]}}, md.rt_val};
    prod = a64 * b64;
  end

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to
  // 0x80000000 without any special case.
  always_comb begin
    neg_a   = !is_uns && md.rs_val[31];
    neg_b   = !is_uns && md.rt_val[31];
    ua      = neg_a ? (32'd0 - md.rs_val) : md.rs_val;
    ub      = neg_b ? (32'd0 - md.rt_val) : md.rt_val;
    ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    quo     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem     = neg_a ? (32'd0 - ur) : ur;
    res_hi  = is_div ? rem : prod[63:32];
    res_lo  = is_div ? quo : prod[31:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (md.start) begin
          unique case (md.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              // divide by zero burns the cycles but leaves HI/LO alone
              pend_wr_d = !(is_div && md.rt_val == 32'd0);
              cnt_d     = is_div ? CW'(DIV_CYCLES)
                                 : CW'(MULT_CYCLES);
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            3'd4:    hi_d = md.rs_val;
            3'd5:    lo_d = md.rs_val;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign md.busy     = busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_stall = busy_q | (md.start & !md.op[2]);

endmodule
